// File: rtl/hm_pkg.sv
// Shared definitions for the heartbeat pulse generator: FSM state encoding,
// default field widths and a small width helper.
package hm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } hm_state_e;

  localparam int PER_W_DEF = 12;
  localparam int PW_W_DEF  = 8;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; the count is
// held at zero while not enabled so every run starts on a fresh boundary.
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic clr,
  input  logic enb,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running modulo-TICK_DIV counter, cleared whenever the generator is idle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (!enb || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  // Gated by enb so a stale count left over from an aborted run never ticks
  assign tick = enb && (cnt_r == LAST);

endmodule

// File: rtl/heartbeat_pulse_gen.sv
// Heartbeat pulse generator: IDLE/HIGH/LOW FSM timed in prescaled ticks,
// with optional finite bursts, beat counting and a sticky config-error flag.
module heartbeat_pulse_gen
  import hm_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int PER_W    = PER_W_DEF,
  parameter int PW_W     = PW_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enb,
  input  logic [PER_W-1:0] period_t,
  input  logic [PW_W-1:0]  width_t,
  input  logic [3:0]       n_beats,
  output logic             pulse,
  output logic [3:0]       beat_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int CNT_W = max_w(PER_W, PW_W);

  hm_state_e        state_r, nx_s;
  logic [CNT_W-1:0] per_r, wid_r, ph_r, low_len_s;
  logic [3:0]       nb_r, burst_r, beat_r;
  logic             pulse_r, busy_r, done_r, err_r;
  logic             tick_s, cfg_ok_s, high_end_s, low_end_s, last_s, done_s;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .clr  (clr),
    .enb  (busy_r),
    .tick (tick_s)
  );

  assign cfg_ok_s   = (period_t != '0) && (width_t != '0) &&
                      (CNT_W'(width_t) < CNT_W'(period_t));
  assign low_len_s  = per_r - wid_r;
  assign high_end_s = tick_s && (ph_r == (wid_r - CNT_W'(1'b1)));
  assign low_end_s  = tick_s && (ph_r == (low_len_s - CNT_W'(1'b1)));
  assign last_s     = (nb_r != 4'd0) && (burst_r == nb_r);

  // Next-state decode; enb low in LOW aborts at once, in HIGH only at phase end
  always_comb begin
    nx_s   = state_r;
    done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enb && cfg_ok_s) begin
          nx_s = ST_HIGH;
        end else begin
          nx_s = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (high_end_s) begin
          nx_s = enb ? ST_LOW : ST_IDLE;
        end else begin
          nx_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (!enb) begin
          nx_s = ST_IDLE;
        end else if (low_end_s && last_s) begin
          nx_s   = ST_IDLE;
          done_s = 1'b1;
        end else if (low_end_s) begin
          nx_s = ST_HIGH;
        end else begin
          nx_s = ST_LOW;
        end
      end
      default: begin
        nx_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= nx_s;
    end
  end

  // Config capture, phase/burst/beat counters and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      per_r   <= '0;
      wid_r   <= '0;
      nb_r    <= 4'd0;
      ph_r    <= '0;
      burst_r <= 4'd0;
      beat_r  <= 4'd0;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && enb) begin
        err_r <= !cfg_ok_s;
      end
      if ((state_r == ST_IDLE) && (nx_s == ST_HIGH)) begin
        per_r <= CNT_W'(period_t);
        wid_r <= CNT_W'(width_t);
        nb_r  <= n_beats;
      end
      if (nx_s != state_r) begin
        ph_r <= '0;
      end else if (tick_s) begin
        ph_r <= ph_r + CNT_W'(1'b1);
      end
      if ((nx_s == ST_HIGH) && (state_r != ST_HIGH)) begin
        beat_r  <= beat_r + 4'd1;
        burst_r <= (state_r == ST_IDLE) ? 4'd1 : (burst_r + 4'd1);
      end else if (nx_s == ST_IDLE) begin
        burst_r <= 4'd0;
      end
      pulse_r <= (nx_s == ST_HIGH);
      busy_r  <= (nx_s != ST_IDLE);
      done_r  <= done_s;
    end
  end

  assign pulse    = pulse_r;
  assign beat_cnt = beat_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign cfg_err  = err_r;

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Directed bench for heartbeat_pulse_gen at TICK_DIV=4: a vector table of
// whole runs measured per cycle, plus hand-written reset/restart sequences.
module tb_heartbeat_pulse_gen;

  logic        clk, clr, enb;
  logic [11:0] period_t;
  logic [7:0]  width_t;
  logic [3:0]  n_beats;
  logic        pulse, busy, done, cfg_err;
  logic [3:0]  beat_cnt;

  int errors = 0;
  int checks = 0;

  heartbeat_pulse_gen #(.TICK_DIV(4), .PER_W(12), .PW_W(8)) dut (
    .clk      (clk),
    .clr      (clr),
    .enb      (enb),
    .period_t (period_t),
    .width_t  (width_t),
    .n_beats  (n_beats),
    .pulse    (pulse),
    .beat_cnt (beat_cnt),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int per, wid, nb, cycles, drop_at, chg_at, chg_per, stop_done;
    int rises, hi_len, lo_len, busy_n, done_n, beat, err, busy_end;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; enb = 1'b0; period_t = 12'd0; width_t = 8'd0; n_beats = 4'd0;
    step();
    step();
    clr = 1'b0;
  endtask

  initial begin
    int rises, hi_min, hi_max, hi_n, lo_min, lo_max, lo_n, busy_n, done_n, cur_len, hcnt;
    bit prev, in_low, seen;

    //          per wid nb cyc drop chg cper stop | rises hi lo busy done beat err bend
    vecs[0] = '{5, 2, 3, 80, -1, -1, 0, 1,   3, 8, 12, 60, 1, 3, 0, 0};
    vecs[1] = '{3, 3, 0, 10, -1, -1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0};
    vecs[2] = '{4, 0, 0, 6, -1, -1, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0};
    vecs[3] = '{2, 1, 0, 130, -1, -1, 0, 0,  17, 4, 4, 130, 0, 1, 0, 1};
    vecs[4] = '{2, 1, 0, 12, 1, -1, 0, 0,    1, 4, 0, 4, 0, 1, 0, 0};
    vecs[5] = '{2, 1, 0, 12, 5, -1, 0, 0,    1, 4, 0, 6, 0, 1, 0, 0};
    vecs[6] = '{5, 2, 2, 60, -1, 3, 1, 1,    2, 8, 12, 40, 1, 2, 0, 0};
    vecs[7] = '{2, 1, 1, 20, -1, -1, 0, 1,   1, 4, 0, 8, 1, 1, 0, 0};
    vecs[8] = '{2, 1, 1, 20, -1, -1, 0, 0,   3, 4, 5, 18, 2, 3, 0, 1};
    vecs[9] = '{0, 1, 0, 6, -1, -1, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0};

    // Reset state while clr is held
    clr = 1'b1; enb = 1'b0; period_t = 12'd0; width_t = 8'd0; n_beats = 4'd0;
    step();
    step();
    check("reset outputs", int'({pulse, beat_cnt, busy, done, cfg_err}), 0);
    clr = 1'b0;

    for (int v = 0; v < NV; v++) begin
      do_reset();
      period_t = 12'(vecs[v].per);
      width_t  = 8'(vecs[v].wid);
      n_beats  = 4'(vecs[v].nb);
      enb      = 1'b1;
      rises = 0; hi_min = 0; hi_max = 0; hi_n = 0; lo_min = 0; lo_max = 0; lo_n = 0;
      busy_n = 0; done_n = 0; cur_len = 0; prev = 1'b0; in_low = 1'b0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step();
        if (pulse && !prev) begin
          rises++;
          if (in_low) begin
            if (lo_n == 0) begin lo_min = cur_len; lo_max = cur_len; end
            else begin
              if (cur_len < lo_min) lo_min = cur_len;
              if (cur_len > lo_max) lo_max = cur_len;
            end
            lo_n++;
          end
          cur_len = 1;
        end else if (!pulse && prev) begin
          if (hi_n == 0) begin hi_min = cur_len; hi_max = cur_len; end
          else begin
            if (cur_len < hi_min) hi_min = cur_len;
            if (cur_len > hi_max) hi_max = cur_len;
          end
          hi_n++;
          cur_len = 1;
          in_low = 1'b1;
        end else begin
          cur_len++;
        end
        prev = pulse;
        if (busy) busy_n++;
        if (done) done_n++;
        if (c == vecs[v].drop_at) enb = 1'b0;
        if (c == vecs[v].chg_at) period_t = 12'(vecs[v].chg_per);
        if (done && (vecs[v].stop_done != 0)) enb = 1'b0;
      end
      check($sformatf("v%0d rises", v), rises, vecs[v].rises);
      check($sformatf("v%0d high min", v), hi_min, vecs[v].hi_len);
      check($sformatf("v%0d high max", v), hi_max, vecs[v].hi_len);
      check($sformatf("v%0d low min", v), lo_min, vecs[v].lo_len);
      check($sformatf("v%0d low max", v), lo_max, vecs[v].lo_len);
      check($sformatf("v%0d busy cycles", v), busy_n, vecs[v].busy_n);
      check($sformatf("v%0d done strobes", v), done_n, vecs[v].done_n);
      check($sformatf("v%0d beat_cnt", v), int'(beat_cnt), vecs[v].beat);
      check($sformatf("v%0d cfg_err", v), int'(cfg_err), vecs[v].err);
      check($sformatf("v%0d busy at end", v), int'(busy), vecs[v].busy_end);
      enb = 1'b0;
    end

    // Illegal config then fix width: error clears and pulsing starts
    do_reset();
    period_t = 12'd3; width_t = 8'd3; n_beats = 4'd0; enb = 1'b1;
    step(); step(); step();
    check("bad cfg err", int'(cfg_err), 1);
    check("bad cfg idle", int'({pulse, busy}), 0);
    width_t = 8'd1;
    step();
    check("fixed cfg err", int'(cfg_err), 0);
    check("fixed cfg start", int'({pulse, busy, beat_cnt}), int'({1'b1, 1'b1, 4'd1}));

    // Asynchronous clear in the middle of HIGH, then restart
    do_reset();
    period_t = 12'd2; width_t = 8'd1; n_beats = 4'd0; enb = 1'b1;
    step(); step();
    check("pre-clr high", int'({pulse, beat_cnt}), int'({1'b1, 4'd1}));
    clr = 1'b1;
    #1;
    check("clr immediate", int'({pulse, beat_cnt, busy, done, cfg_err}), 0);
    step();
    clr = 1'b0;
    step();
    check("restart after clr", int'({pulse, beat_cnt}), int'({1'b1, 4'd1}));

    // Abort in LOW, restart at once: prescaler must begin a fresh tick
    do_reset();
    period_t = 12'd2; width_t = 8'd1; n_beats = 4'd0; enb = 1'b1;
    for (int c = 0; c < 6; c++) step();
    enb = 1'b0;
    step();
    check("low abort idle", int'(busy), 0);
    enb = 1'b1;
    hcnt = 0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (pulse) begin hcnt++; seen = 1'b1; end
      else if (seen) break;
    end
    check("restart high length", hcnt, 4);
    enb = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
